// File: rtl/axil_m_cmd.sv
// Single-outstanding AXI-Lite master: turns one request/response command into
// one AXI-Lite read or write transaction and returns the slave's reply.
module axil_m_cmd #(
    parameter int AXIL_DATA_WIDTH = 64,
    parameter int AXIL_ADDR_WIDTH = 32,
    localparam int STRB_W = AXIL_DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    // command side
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [AXIL_ADDR_WIDTH-1:0] req_addr,
    input  logic [AXIL_DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_W-1:0]          req_wstrb,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_write,
    output logic [AXIL_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                 rsp_resp,
    // AXI-Lite master
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]                 m_axil_awprot,
    output logic                       m_axil_awvalid,
    input  logic                       m_axil_awready,
    output logic [AXIL_DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_W-1:0]          m_axil_wstrb,
    output logic                       m_axil_wvalid,
    input  logic                       m_axil_wready,
    input  logic [1:0]                 m_axil_bresp,
    input  logic                       m_axil_bvalid,
    output logic                       m_axil_bready,
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]                 m_axil_arprot,
    output logic                       m_axil_arvalid,
    input  logic                       m_axil_arready,
    input  logic [AXIL_DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]                 m_axil_rresp,
    input  logic                       m_axil_rvalid,
    output logic                       m_axil_rready
);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP
    } state_t;

    state_t                     r_state, w_next;
    logic [AXIL_ADDR_WIDTH-1:0] r_addr;
    logic [AXIL_DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]          r_wstrb;
    logic                       r_aw_done, r_w_done;
    logic [AXIL_DATA_WIDTH-1:0] r_rsp_rdata;
    logic [1:0]                 r_rsp_resp;
    logic                       r_rsp_write;

    logic w_req_fire, w_aw_fire, w_w_fire, w_aw_fin, w_w_fin;

    assign w_req_fire = req_valid && req_ready;
    assign w_aw_fire  = m_axil_awvalid && m_axil_awready;
    assign w_w_fire   = m_axil_wvalid && m_axil_wready;
    // Count a channel as done in the very cycle its handshake completes.
    assign w_aw_fin   = r_aw_done || w_aw_fire;
    assign w_w_fin    = r_w_done || w_w_fire;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = !rst;
                if (w_req_fire) w_next = req_write ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                // Valids depend only on the state and done flops, never on ready.
                m_axil_awvalid = !r_aw_done;
                m_axil_wvalid  = !r_w_done;
                if (w_aw_fin && w_w_fin) w_next = WR_RESP;
            end
            WR_RESP: begin
                m_axil_bready = 1'b1;
                if (m_axil_bvalid) w_next = RSP;
            end
            RD_REQ: begin
                m_axil_arvalid = 1'b1;
                if (m_axil_arready) w_next = RD_RESP;
            end
            RD_RESP: begin
                m_axil_rready = 1'b1;
                if (m_axil_rvalid) w_next = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
            r_rsp_write <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_wstrb   <= req_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (r_state == WR_REQ) begin
                if (w_aw_fire) r_aw_done <= 1'b1;
                if (w_w_fire)  r_w_done  <= 1'b1;
            end
            if (r_state == WR_RESP && m_axil_bvalid) begin
                r_rsp_resp  <= m_axil_bresp;
                r_rsp_write <= 1'b1;
                r_rsp_rdata <= '0;
            end
            if (r_state == RD_RESP && m_axil_rvalid) begin
                r_rsp_rdata <= m_axil_rdata;
                r_rsp_resp  <= m_axil_rresp;
                r_rsp_write <= 1'b0;
            end
        end
    end

    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_write     = r_rsp_write;
    assign m_axil_awaddr = r_addr;
    assign m_axil_araddr = r_addr;
    assign m_axil_wdata  = r_wdata;
    assign m_axil_wstrb  = r_wstrb;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;

endmodule
